// File: rtl/cache_port_arbiter.sv
// Two-master arbiter for the single cache slave port: fetch (M0, read-only) and load/store (M1).
// One outstanding read at a time; returning data is routed combinationally to its owner.
module cache_port_arbiter #(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  // fetch master
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_read_i,
  input  logic                m0_abort_i,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdata_valid_o,
  output logic                m0_waitrequest_o,
  // load/store master
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W/8-1:0] m1_byte_en_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdata_valid_o,
  output logic                m1_waitrequest_o,
  // cache slave
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W/8-1:0] s_byte_en_o,
  output logic [DATA_W-1:0]   s_writedata_o,
  output logic                s_read_o,
  output logic                s_write_o,
  input  logic [DATA_W-1:0]   s_readdata_i,
  input  logic                s_readdata_valid_i,
  input  logic                s_waitrequest_i,
  // status
  output logic                busy_o,
  output logic                owner_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StRdM0, StRdM1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            drop_q, drop_d;

  logic m1_req, force_m0, grant_m0, grant_m1, accept;

  always_comb begin
    m1_req   = m1_read_i | m1_write_i;
    force_m0 = m0_read_i && (starve_q == StarveMax);
    grant_m1 = (state_q == StIdle) && m1_req && !force_m0;
    grant_m0 = (state_q == StIdle) && m0_read_i && !grant_m1;
    accept   = !s_waitrequest_i;
  end

  // Next-state: FSM, fetch-drop flag and starvation counter
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    starve_d = starve_q;
    case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (accept) begin
          if (grant_m0) begin
            state_d = StRdM0;
          end else if (grant_m1 && m1_read_i) begin
            state_d = StRdM1;
          end
        end
      end
      StRdM0: begin
        if (s_readdata_valid_i) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end else if (m0_abort_i) begin
          drop_d = 1'b1;
        end
      end
      StRdM1: begin
        if (s_readdata_valid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!m0_read_i || (grant_m0 && accept)) begin
      starve_d = '0;
    end else if (grant_m1 && accept && (starve_q != StarveMax)) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // All outputs are combinational from registered state; reset forces idle values.
  always_comb begin
    s_addr_o            = '0;
    s_byte_en_o         = '0;
    s_writedata_o       = '0;
    s_read_o            = 1'b0;
    s_write_o           = 1'b0;
    m0_waitrequest_o    = 1'b1;
    m1_waitrequest_o    = 1'b1;
    m0_readdata_valid_o = 1'b0;
    m1_readdata_valid_o = 1'b0;
    m0_readdata_o       = '0;
    m1_readdata_o       = '0;
    busy_o              = 1'b0;
    owner_o             = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          if (grant_m1) begin
            s_addr_o         = m1_addr_i;
            s_byte_en_o      = m1_byte_en_i;
            s_writedata_o    = m1_writedata_i;
            s_read_o         = m1_read_i;
            s_write_o        = m1_write_i;
            m1_waitrequest_o = s_waitrequest_i;
          end else if (grant_m0) begin
            s_addr_o         = m0_addr_i;
            s_read_o         = 1'b1;
            m0_waitrequest_o = s_waitrequest_i;
          end
        end
        StRdM0: begin
          busy_o = 1'b1;
          if (s_readdata_valid_i && !drop_q && !m0_abort_i) begin
            m0_readdata_valid_o = 1'b1;
            m0_readdata_o       = s_readdata_i;
          end
        end
        StRdM1: begin
          busy_o  = 1'b1;
          owner_o = 1'b1;
          if (s_readdata_valid_i) begin
            m1_readdata_valid_o = 1'b1;
            m1_readdata_o       = s_readdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      starve_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios then random traffic, each cycle compared
// against a transaction-level model of the arbitration rules.
module tb_cache_port_arbiter;

  localparam int unsigned ADDR_W     = 25;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_W-1:0]   m0_addr_i;
  logic                m0_read_i, m0_abort_i;
  logic [DATA_W-1:0]   m0_readdata_o;
  logic                m0_readdata_valid_o, m0_waitrequest_o;
  logic [ADDR_W-1:0]   m1_addr_i;
  logic [DATA_W/8-1:0] m1_byte_en_i;
  logic [DATA_W-1:0]   m1_writedata_i;
  logic                m1_read_i, m1_write_i;
  logic [DATA_W-1:0]   m1_readdata_o;
  logic                m1_readdata_valid_o, m1_waitrequest_o;
  logic [ADDR_W-1:0]   s_addr_o;
  logic [DATA_W/8-1:0] s_byte_en_o;
  logic [DATA_W-1:0]   s_writedata_o;
  logic                s_read_o, s_write_o;
  logic [DATA_W-1:0]   s_readdata_i;
  logic                s_readdata_valid_i, s_waitrequest_i;
  logic                busy_o, owner_o;

  cache_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .m0_addr_i          (m0_addr_i),
    .m0_read_i          (m0_read_i),
    .m0_abort_i         (m0_abort_i),
    .m0_readdata_o      (m0_readdata_o),
    .m0_readdata_valid_o(m0_readdata_valid_o),
    .m0_waitrequest_o   (m0_waitrequest_o),
    .m1_addr_i          (m1_addr_i),
    .m1_byte_en_i       (m1_byte_en_i),
    .m1_writedata_i     (m1_writedata_i),
    .m1_read_i          (m1_read_i),
    .m1_write_i         (m1_write_i),
    .m1_readdata_o      (m1_readdata_o),
    .m1_readdata_valid_o(m1_readdata_valid_o),
    .m1_waitrequest_o   (m1_waitrequest_o),
    .s_addr_o           (s_addr_o),
    .s_byte_en_o        (s_byte_en_o),
    .s_writedata_o      (s_writedata_o),
    .s_read_o           (s_read_o),
    .s_write_o          (s_write_o),
    .s_readdata_i       (s_readdata_i),
    .s_readdata_valid_i (s_readdata_valid_i),
    .s_waitrequest_i    (s_waitrequest_i),
    .busy_o             (busy_o),
    .owner_o            (owner_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: which master owns the outstanding read (-1 none), drop request, starvation count.
  int   md_owner  = -1;
  bit   md_drop   = 1'b0;
  int   md_starve = 0;
  int   md_winner;

  logic [ADDR_W-1:0]   e_saddr;
  logic [DATA_W/8-1:0] e_sbe;
  logic [DATA_W-1:0]   e_swd, e_m0d, e_m1d;
  logic e_sread, e_swrite, e_m0w, e_m1w, e_m0v, e_m1v, e_busy, e_owner;

  // Last sampled DUT outputs, used by the directed scenario checks.
  logic                o_sread, o_swrite, o_m0w, o_m1w, o_m0v, o_m1v, o_busy;
  logic [ADDR_W-1:0]   o_saddr;
  logic [DATA_W/8-1:0] o_sbe;
  logic [DATA_W-1:0]   o_m0d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    e_saddr = '0; e_sbe = '0; e_swd = '0; e_sread = 0; e_swrite = 0;
    e_m0w = 1; e_m1w = 1; e_m0v = 0; e_m1v = 0; e_m0d = '0; e_m1d = '0;
    e_busy = 0; e_owner = 0;
    md_winner = -1;
    if (!rst) begin
      if (md_owner < 0) begin
        if ((m1_read_i || m1_write_i) && !(md_starve == STARVE_MAX && m0_read_i)) md_winner = 1;
        else if (m0_read_i) md_winner = 0;
        if (md_winner == 1) begin
          e_saddr = m1_addr_i; e_sbe = m1_byte_en_i; e_swd = m1_writedata_i;
          e_sread = m1_read_i; e_swrite = m1_write_i; e_m1w = s_waitrequest_i;
        end else if (md_winner == 0) begin
          e_saddr = m0_addr_i; e_sread = 1; e_m0w = s_waitrequest_i;
        end
      end else begin
        e_busy  = 1;
        e_owner = (md_owner == 1);
        if (s_readdata_valid_i) begin
          if (md_owner == 1) begin
            e_m1v = 1; e_m1d = s_readdata_i;
          end else if (!md_drop && !m0_abort_i) begin
            e_m0v = 1; e_m0d = s_readdata_i;
          end
        end
      end
    end
  endtask

  task automatic model_update();
    bit acc;
    acc = !s_waitrequest_i;
    if (rst) begin
      md_owner = -1; md_drop = 0; md_starve = 0;
    end else begin
      if (!m0_read_i || (md_winner == 0 && acc)) md_starve = 0;
      else if (md_winner == 1 && acc && md_starve < STARVE_MAX) md_starve++;
      if (md_owner < 0) begin
        md_drop = 0;
        if (acc && md_winner == 0) md_owner = 0;
        else if (acc && md_winner == 1 && m1_read_i) md_owner = 1;
      end else if (s_readdata_valid_i) begin
        md_owner = -1; md_drop = 0;
      end else if (md_owner == 0 && m0_abort_i) begin
        md_drop = 1;
      end
    end
  endtask

  // One clock: compare every output mid-cycle, then advance the model at the edge.
  task automatic cycle();
    @(negedge clk);
    model_outputs();
    chk("s_addr", s_addr_o, e_saddr);
    chk("s_byte_en", s_byte_en_o, e_sbe);
    chk("s_writedata", s_writedata_o, e_swd);
    chk("s_read", s_read_o, e_sread);
    chk("s_write", s_write_o, e_swrite);
    chk("m0_wait", m0_waitrequest_o, e_m0w);
    chk("m1_wait", m1_waitrequest_o, e_m1w);
    chk("m0_valid", m0_readdata_valid_o, e_m0v);
    chk("m1_valid", m1_readdata_valid_o, e_m1v);
    chk("m0_data", m0_readdata_o, e_m0d);
    chk("m1_data", m1_readdata_o, e_m1d);
    chk("busy", busy_o, e_busy);
    chk("owner", owner_o, e_owner);
    o_sread = s_read_o; o_swrite = s_write_o; o_m0w = m0_waitrequest_o;
    o_m1w = m1_waitrequest_o; o_m0v = m0_readdata_valid_o; o_m1v = m1_readdata_valid_o;
    o_busy = busy_o; o_saddr = s_addr_o; o_sbe = s_byte_en_o; o_m0d = m0_readdata_o;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    m0_addr_i = '0; m0_read_i = 0; m0_abort_i = 0;
    m1_addr_i = '0; m1_byte_en_i = '0; m1_writedata_i = '0; m1_read_i = 0; m1_write_i = 0;
    s_readdata_i = '0; s_readdata_valid_i = 0; s_waitrequest_i = 0;
  endtask

  initial begin
    int n_busy, n_sread, n_wr, n_wait;
    bit got;
    quiet();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // Lone fetch read, data three cycles after issue
    m0_addr_i = 25'h10; m0_read_i = 1;
    n_busy = 0; n_sread = 0;
    cycle();
    n_sread += int'(o_sread);
    m0_read_i = 0;
    cycle(); n_busy += int'(o_busy); n_sread += int'(o_sread);
    cycle(); n_busy += int'(o_busy); n_sread += int'(o_sread);
    s_readdata_valid_i = 1; s_readdata_i = 32'hDEADBEEF;
    cycle(); n_busy += int'(o_busy);
    chk("p1_m0_valid", o_m0v, 1'b1);
    chk("p1_m0_data", o_m0d, 32'hDEADBEEF);
    s_readdata_valid_i = 0; s_readdata_i = '0;
    chk("p1_busy_cycles", n_busy, 3);
    chk("p1_sread_pulses", n_sread, 1);

    // Simultaneous reads: M1 first, M0 the cycle after M1's data
    m0_addr_i = 25'h40; m0_read_i = 1; m1_addr_i = 25'h1234; m1_read_i = 1;
    cycle();
    chk("p2_first_addr", o_saddr, 25'h1234);
    chk("p2_m0_wait", o_m0w, 1'b1);
    m1_read_i = 0;
    cycle();
    s_readdata_valid_i = 1; s_readdata_i = 32'h0BAD_F00D;
    cycle();
    chk("p2_m1_valid", o_m1v, 1'b1);
    s_readdata_valid_i = 0;
    cycle();
    chk("p2_m0_issued", o_sread, 1'b1);
    chk("p2_m0_addr", o_saddr, 25'h40);
    m0_read_i = 0;
    s_readdata_valid_i = 1; s_readdata_i = 32'h11;
    cycle();
    quiet();
    cycle();

    // Starvation bound: continuous M1 writes with a pending fetch
    m1_write_i = 1; m1_addr_i = 25'h200; m1_byte_en_i = 4'hF; m1_writedata_i = 32'h5555;
    m0_read_i = 1; m0_addr_i = 25'h80;
    n_wr = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      cycle();
      if (o_swrite && !o_m1w) n_wr++;
      if (o_sread && !o_m0w) got = 1;
    end
    chk("p3_m0_granted", got, 1'b1);
    chk("p3_writes_before_m0", n_wr, STARVE_MAX);
    quiet();
    m1_write_i = 1; m1_addr_i = 25'h200;
    s_readdata_valid_i = 1;
    cycle();
    quiet();
    cycle();

    // Abort mid-wait suppresses the data; the next fetch is delivered
    m0_addr_i = 25'h20; m0_read_i = 1;
    cycle();
    m0_read_i = 0;
    cycle();
    m0_abort_i = 1;
    cycle();
    m0_abort_i = 0;
    cycle();
    s_readdata_valid_i = 1; s_readdata_i = 32'h12345678;
    cycle();
    chk("p4_aborted_valid", o_m0v, 1'b0);
    s_readdata_valid_i = 0;
    m0_addr_i = 25'h24; m0_read_i = 1;
    cycle();
    m0_read_i = 0;
    s_readdata_valid_i = 1; s_readdata_i = 32'hCAFEF00D;
    cycle();
    chk("p4_next_valid", o_m0v, 1'b1);
    chk("p4_next_data", o_m0d, 32'hCAFEF00D);
    quiet();

    // Cache stall on an M1 write with byte_en 0x3
    m1_write_i = 1; m1_addr_i = 25'h300; m1_byte_en_i = 4'h3; m1_writedata_i = 32'hA5A5;
    s_waitrequest_i = 1;
    n_wait = 0; n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_wait += int'(o_m1w);
      if (o_swrite && !o_m1w) n_wr++;
    end
    s_waitrequest_i = 0;
    cycle();
    n_wait += int'(o_m1w);
    if (o_swrite && !o_m1w) n_wr++;
    chk("p5_byte_en", o_sbe, 4'h3);
    m1_write_i = 0;
    cycle();
    if (o_swrite && !o_m1w) n_wr++;
    chk("p5_wait_cycles", n_wait, 5);
    chk("p5_accepted", n_wr, 1);

    // Reset during an M1 read, then late data
    m1_read_i = 1; m1_addr_i = 25'h400;
    cycle();
    m1_read_i = 0;
    cycle();
    chk("p6_busy_before_rst", o_busy, 1'b1);
    rst = 1;
    cycle();
    chk("p6_busy_in_rst", o_busy, 1'b0);
    rst = 0;
    s_readdata_valid_i = 1; s_readdata_i = 32'h77;
    cycle();
    chk("p6_stray_m1_valid", o_m1v, 1'b0);
    chk("p6_stray_m0_valid", o_m0v, 1'b0);
    quiet();
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      m0_addr_i = ADDR_W'($urandom);
      m0_read_i = ($urandom_range(0, 2) != 0);
      m0_abort_i = ($urandom_range(0, 5) == 0);
      m1_addr_i = ADDR_W'($urandom);
      m1_byte_en_i = 4'($urandom);
      m1_writedata_i = $urandom;
      case ($urandom_range(0, 3))
        0: begin m1_read_i = 1; m1_write_i = 0; end
        1: begin m1_read_i = 0; m1_write_i = 1; end
        default: begin m1_read_i = 0; m1_write_i = 0; end
      endcase
      s_readdata_i = $urandom;
      s_readdata_valid_i = ($urandom_range(0, 2) == 0);
      s_waitrequest_i = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
